// File: rtl/clk_count_hr_cfg.sv
// clk_count_hr_cfg: 0..23 hour counter with 12/24-hour display mapping,
// an AM/PM flag and day carry/borrow pulses.
// Supports increment, decrement, preset load and a synchronous clear.
// Optional build macro HR_BCD_EN: hr is presented as two BCD digits
// (units in hr[3:0], tens in hr[5:4]) instead of plain binary.
// WIDTH must be in 6..16; bits above the display value are always zero.
module clk_count_hr_cfg #(
    parameter int WIDTH         = 8,
    parameter bit TWELVE_AT_TOP = 1'b0
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             rst_counters,
    input  logic             count_up_hr,
    input  logic             count_dn_hr,
    input  logic             load,
    input  logic [4:0]       load_val,
    input  logic             mode_24,
    output logic [WIDTH-1:0] hr,
    output logic             pm,
    output logic             carry_day,
    output logic             borrow_day,
    output logic             load_err
);

    localparam logic [4:0] HR_MAX = 5'd23;
    localparam logic [4:0] HR_NOON = 5'd12;

    logic [4:0]       hr24_q, hr24_d;
    logic [WIDTH-1:0] hr_q, hr_d;
    logic             pm_q, pm_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             lerr_q, lerr_d;

    // Map a 0..23 hour onto the display value for the selected mode and
    // encoding.
    function automatic logic [WIDTH-1:0] disp(input logic [4:0] h24,
                                              input logic       m24);
        logic [WIDTH-1:0] r;
        logic [4:0]       v;
        logic [4:0]       u5;
        logic [1:0]       t;
        r  = '0;
        v  = h24;
        u5 = '0;
        t  = '0;
        if (!m24) begin
            v = (h24 >= HR_NOON) ? h24 - HR_NOON : h24;
            if (TWELVE_AT_TOP && (v == 5'd0))
                v = HR_NOON;
        end
`ifdef HR_BCD_EN
        if (v >= 5'd20) begin
            t  = 2'd2;
            u5 = v - 5'd20;
        end else if (v >= 5'd10) begin
            t  = 2'd1;
            u5 = v - 5'd10;
        end else begin
            t  = 2'd0;
            u5 = v;
        end
        r[3:0] = u5[3:0];
        r[5:4] = t;
`else
        r[4:0] = v;
`endif
        return r;
    endfunction

    // Next hour by priority: clear, load, up+down cancel, up, down, hold.
    // Display and pm are derived from the next hour so all outputs are
    // registered yet reflect the edge that changed them.
    always_comb begin
        hr24_d   = hr24_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        lerr_d   = 1'b0;
        if (rst_counters) begin
            hr24_d = 5'd0;
        end else if (load) begin
            if (load_val <= HR_MAX)
                hr24_d = load_val;
            else
                lerr_d = 1'b1;
        end else if (count_up_hr && count_dn_hr) begin
            hr24_d = hr24_q;
        end else if (count_up_hr) begin
            if (hr24_q == HR_MAX) begin
                hr24_d  = 5'd0;
                carry_d = 1'b1;
            end else begin
                hr24_d = hr24_q + 5'd1;
            end
        end else if (count_dn_hr) begin
            if (hr24_q == 5'd0) begin
                hr24_d   = HR_MAX;
                borrow_d = 1'b1;
            end else begin
                hr24_d = hr24_q - 5'd1;
            end
        end
        hr_d = disp(hr24_d, mode_24);
        pm_d = (hr24_d >= HR_NOON);
    end

    // State and output registers. mode_24 is a quasi-static setting, so the
    // reset display value (12 in 12-hour top-of-dial style) follows it.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            hr24_q   <= 5'd0;
            hr_q     <= disp(5'd0, mode_24);
            pm_q     <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            hr24_q   <= hr24_d;
            hr_q     <= hr_d;
            pm_q     <= pm_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            lerr_q   <= lerr_d;
        end
    end

    assign hr         = hr_q;
    assign pm         = pm_q;
    assign carry_day  = carry_q;
    assign borrow_day = borrow_q;
    assign load_err   = lerr_q;

endmodule

// File: tb/tb_clk_count_hr_cfg.sv
// Scoreboard bench for clk_count_hr_cfg: two instances (both 12-hour
// display styles) share stimulus; a reference model pushes expectations,
// a monitor pops and compares one cycle later.
module tb_clk_count_hr_cfg;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         rst = 1'b0;
    logic         rst_counters = 1'b0;
    logic         count_up_hr = 1'b0;
    logic         count_dn_hr = 1'b0;
    logic         load = 1'b0;
    logic [4:0]   load_val = '0;
    logic         mode_24 = 1'b0;
    logic [W-1:0] hr0, hr1;
    logic         pm0, pm1, cy0, cy1, bw0, bw1, le0, le1;

    clk_count_hr_cfg #(.WIDTH(W), .TWELVE_AT_TOP(1'b0)) dut0 (
        .CLK(CLK), .rst(rst), .rst_counters(rst_counters),
        .count_up_hr(count_up_hr), .count_dn_hr(count_dn_hr),
        .load(load), .load_val(load_val), .mode_24(mode_24),
        .hr(hr0), .pm(pm0), .carry_day(cy0), .borrow_day(bw0), .load_err(le0));

    clk_count_hr_cfg #(.WIDTH(W), .TWELVE_AT_TOP(1'b1)) dut1 (
        .CLK(CLK), .rst(rst), .rst_counters(rst_counters),
        .count_up_hr(count_up_hr), .count_dn_hr(count_dn_hr),
        .load(load), .load_val(load_val), .mode_24(mode_24),
        .hr(hr1), .pm(pm1), .carry_day(cy1), .borrow_day(bw1), .load_err(le1));

    always #5 CLK = ~CLK;

    typedef struct {
        int hr0;
        int hr1;
        int pm;
        int carry;
        int borrow;
        int lerr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   h = 0;  // model hour of day, 0..23

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Display value as a human would read the clock face.
    function automatic int face(input int hh, input bit m24, input bit top);
        int v;
        if (m24) v = hh;
        else begin
            v = hh % 12;
            if (top && v == 0) v = 12;
        end
`ifdef HR_BCD_EN
        return (v / 10) * 16 + (v % 10);
`else
        return v;
`endif
    endfunction

    // Drive one cycle of inputs and predict the outcome of the next edge.
    task automatic step(input bit up, input bit dn, input bit ld, input int lv,
                        input bit rc, input bit m24);
        exp_t e;
        @(negedge CLK);
        #1;
        count_up_hr = up; count_dn_hr = dn; load = ld;
        load_val = 5'(lv); rst_counters = rc; mode_24 = m24;
        e.carry = 0; e.borrow = 0; e.lerr = 0;
        if (rc) h = 0;
        else if (ld) begin
            if (lv <= 23) h = lv;
            else e.lerr = 1;
        end else if (up && !dn) begin
            e.carry = (h == 23);
            h = (h + 1) % 24;
        end else if (dn && !up) begin
            e.borrow = (h == 0);
            h = (h + 23) % 24;
        end
        e.hr0 = face(h, m24, 1'b0);
        e.hr1 = face(h, m24, 1'b1);
        e.pm  = (h >= 12);
        q.push_back(e);
    endtask

    task automatic idle(input bit m24);
        step(0, 0, 0, 0, 0, m24);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: every edge, compare what the DUTs present with the oldest
    // expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hr_top0", int'(hr0), e.hr0);
                chk("hr_top1", int'(hr1), e.hr1);
                chk("pm", int'(pm0), e.pm);
                chk("pm_top1", int'(pm1), e.pm);
                chk("carry_day", int'(cy0), e.carry);
                chk("borrow_day", int'(bw0), e.borrow);
                chk("load_err", int'(le0), e.lerr);
                chk("pulses_top1", int'({cy1, bw1, le1}), (e.carry << 2) | (e.borrow << 1) | e.lerr);
            end
        end
    end

    initial begin
        // Reset in 12-hour mode: top-of-dial instance shows 12.
        mode_24 = 1'b0;
        rst = 1'b1;
        #12;
        chk("rst_hr_top0", int'(hr0), 0);
        chk("rst_hr_top1", int'(hr1), face(0, 1'b0, 1'b1));
        chk("rst_pm", int'(pm0), 0);
        chk("rst_pulses", int'({cy0, bw0, le0}), 0);
        @(negedge CLK);
        rst = 1'b0;
        h = 0;

        // 24 ups in 24-hour mode: 1..23 then wrap with carry.
        for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 0, 1);
        idle(1);

        // 12-hour mode from midnight: 12,1..11 AM then 12 PM.
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);

        // Borrow from midnight.
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(0);

        // Illegal load, then load masking a count.
        step(0, 0, 1, 25, 0, 1);
        step(0, 0, 1, 31, 0, 1);
        step(0, 0, 1, 23, 0, 1);
        step(1, 0, 1, 7, 0, 1);
        step(1, 0, 1, 23, 0, 1);
        step(1, 0, 0, 0, 1, 1);   // clear masks the carry
        step(0, 1, 0, 0, 1, 1);   // clear masks the borrow

        // Up+down at 23: hold. Then async reset mid-cycle with a pending up.
        step(0, 0, 1, 23, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);   // 23 -> 0 with carry, pulse high
        drain();
        @(posedge CLK);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_hr", int'(hr0), 0);
        chk("arst_pm", int'(pm0), 0);
        chk("arst_carry", int'(cy0), 0);
        h = 0;
        @(negedge CLK);
        #1;
        rst = 1'b0;
        count_up_hr = 1'b0;

        // Load 19 in 24-hour mode, then remap to 12-hour on the next edge.
        step(0, 0, 1, 19, 0, 1);
        idle(0);
        idle(0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit m;
            m = ($urandom_range(0, 9) < 5);
            step($urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 31),
                 ($urandom_range(0, 19) == 0), m);
        end
        idle(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_count_hr_cfg.md
# clk_count_hr_cfg

Parametrised hour counter for the digital clock datapath, superseding the fixed 12-hour counter. It holds the time of day as a 0..23 hour state. It presents that state as a 12-hour or 24-hour display value (runtime selectable) with an AM/PM flag, and supports increment, decrement and preset load. Day carry and borrow pulses feed the calendar/day logic. Increment pulses come from the minutes stage; decrement and load come from the time-set controller.

## Interface
Parameters:
- WIDTH, 8, width of hr output; legal range 6..16; upper bits zero-filled.
- TWELVE_AT_TOP, 0, 12-hour display style: 0 shows 0..11, 1 shows 12,1..11 (state 0/12 displays 12).

Ports:
- CLK  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rst_counters  in  1  synchronous clear to hour 0 (midnight).
- count_up_hr  in  1  single-cycle increment request.
- count_dn_hr  in  1  single-cycle decrement request.
- load  in  1  synchronous preset strobe.
- load_val  in  5  preset value, binary 24-hour, 0..23 legal.
- mode_24  in  1  1 = 24-hour display, 0 = 12-hour display.
- hr  out  WIDTH  displayed hour, registered.
- pm  out  1  1 when state ≥ 12, in both modes; registered.
- carry_day  out  1  one-cycle pulse on upward wrap 23→0.
- borrow_day  out  1  one-cycle pulse on downward wrap 0→23.
- load_err  out  1  one-cycle pulse when load_val > 23.

## Operation
- Internal state hr24, 5 bits, range 0..23, never leaves range.
- Per-edge priority, highest first:
  1. rst_counters: hr24 = 0.
  2. load: if load_val ≤ 23, hr24 = load_val; otherwise hr24 is unchanged and load_err pulses.
  3. count_up_hr and count_dn_hr both high: hr24 is unchanged; no pulse.
  4. count_up_hr: hr24 = hr24+1. At 23 it wraps to 0 and carry_day pulses.
  5. count_dn_hr: hr24 = hr24−1. At 0 it wraps to 23 and borrow_day pulses.
  6. Otherwise hold.
- A load or rst_counters in the same cycle as a count masks the count and its carry/borrow.
- Display mapping, computed from the next-state value and current mode_24:
  - 24-hour: hr = hr24.
  - 12-hour: h = hr24 mod 12. hr = h when TWELVE_AT_TOP=0. When TWELVE_AT_TOP=1, hr = 12 if h = 0, else h.
- pm = (next hr24 ≥ 12).
- Changing mode_24 does not alter hr24. It only remaps hr at the next edge.
- Reset values: hr24 = 0, pm = 0, carry_day = 0, borrow_day = 0, load_err = 0. hr = 0, except 12-hour mode with TWELVE_AT_TOP=1, where hr = 12 (binary 12, or BCD 0x12).
- The async reset forces these values immediately, mid-operation, regardless of any pending strobe.

## Timing
- Latency is one cycle. Inputs are sampled at edge N; hr, pm and the pulses reflect them right after edge N.
- Pulses are high for exactly one cycle, the cycle after the causing edge.
- Inputs are synchronous to CLK. No handshake: a request held high for k cycles produces k steps.
- No combinational path from input to output.

## Configuration
- HR_BCD_EN defined: hr carries two BCD digits. Units are in hr[3:0], tens in hr[5:4], and hr[WIDTH-1:6] = 0. Example: hour 23 in 24-hour mode gives 0x23.
- HR_BCD_EN undefined: hr is plain binary, zero-extended. Example: hour 23 gives 0x17.
- pm, the pulses and the internal state are identical in both builds.

## Test plan
- Reset, then 24 count_up_hr pulses in 24-hour mode, binary build: hr steps 0..23 then 0. carry_day pulses once, on the 24th step. pm is 1 for values 12..23.
- 12-hour mode, TWELVE_AT_TOP=1, load_val=0 then 12 up pulses: hr sequence is 12,1,..,11 with pm=0, then 12 with pm=1.
- hr24=0, count_dn_hr: hr24 becomes 23 and borrow_day pulses. In 12-hour mode with TWELVE_AT_TOP=0, hr=11 and pm=1.
- load=1 with load_val=25: load_err pulses and hr is unchanged. load with load_val=7 together with count_up_hr: hr=7 and no carry_day.
- count_up_hr and count_dn_hr high together at hr24=23: no change and no pulses. Then assert rst mid-cycle: hr and pm go to 0 asynchronously, before the next edge.
- HR_BCD_EN build: load 19 with mode_24=1 gives hr=0x19. Switch mode_24 to 0: the next edge gives hr=0x07 and pm=1.
